// File: rtl/load_store_unit.sv
// Data-memory initiator: sequences one load or store over WAIT_CYCLES selector
// cycles against a combinational memory and reports completion or misalignment.
module load_store_unit #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     LoadStore_CLOCK_50,
  input  logic                     LoadStore_RESET_InHigh,
  input  logic                     LoadStore_Req_In,
  input  logic                     LoadStore_Write_In,
  input  logic [DATAWIDTH_BUS-1:0] LoadStore_Address_In,
  input  logic [DATAWIDTH_BUS-1:0] LoadStore_Data_In,
  output logic [DATAWIDTH_BUS-1:0] LoadStore_Data_Out,
  output logic                     LoadStore_Busy_Out,
  output logic                     LoadStore_Done_Out,
  output logic                     LoadStore_Error_Out,
  output logic [DATAWIDTH_BUS-1:0] LoadStore_MemAddress_Out,
  output logic [DATAWIDTH_BUS-1:0] LoadStore_MemData_Out,
  output logic                     LoadStore_MemRD_Out,
  output logic                     LoadStore_MemWR_Out,
  input  logic [DATAWIDTH_BUS-1:0] LoadStore_MemData_In
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // The counter starts at WAIT_CYCLES-1 so the selector spans exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                   state_r;
  logic [3:0]               waitCount_r;
  logic                     writeLatch_r;
  logic [DATAWIDTH_BUS-1:0] dataOut_r;
  logic [DATAWIDTH_BUS-1:0] memAddress_r;
  logic [DATAWIDTH_BUS-1:0] memData_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     error_r;
  logic                     memRd_r;
  logic                     memWr_r;

  // Access sequencer; every output is a register so reset clears selectors immediately.
  always_ff @(posedge LoadStore_CLOCK_50 or posedge LoadStore_RESET_InHigh) begin
    if (LoadStore_RESET_InHigh) begin
      state_r      <= IDLE;
      waitCount_r  <= 4'd0;
      writeLatch_r <= 1'b0;
      dataOut_r    <= '0;
      memAddress_r <= '0;
      memData_r    <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      memRd_r      <= 1'b0;
      memWr_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (LoadStore_Req_In) begin
            memAddress_r <= LoadStore_Address_In;
            memData_r    <= LoadStore_Data_In;
            writeLatch_r <= LoadStore_Write_In;
            busy_r       <= 1'b1;
            if (LoadStore_Address_In[1:0] != 2'b00) begin
              done_r  <= 1'b1;
              error_r <= 1'b1;
              state_r <= ERROR;
            end else begin
              waitCount_r <= WAIT_LOAD;
              memRd_r     <= ~LoadStore_Write_In;
              memWr_r     <= LoadStore_Write_In;
              state_r     <= ACCESS;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ACCESS: begin
          if (waitCount_r == 4'd0) begin
            if (!writeLatch_r) begin
              dataOut_r <= LoadStore_MemData_In;
            end
            memRd_r <= 1'b0;
            memWr_r <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            waitCount_r <= waitCount_r - 4'd1;
          end
        end
        DONE, ERROR: begin
          done_r  <= 1'b0;
          error_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          error_r <= 1'b0;
          busy_r  <= 1'b0;
          memRd_r <= 1'b0;
          memWr_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign LoadStore_Data_Out       = dataOut_r;
  assign LoadStore_Busy_Out       = busy_r;
  assign LoadStore_Done_Out       = done_r;
  assign LoadStore_Error_Out      = error_r;
  assign LoadStore_MemAddress_Out = memAddress_r;
  assign LoadStore_MemData_Out    = memData_r;
  assign LoadStore_MemRD_Out      = memRd_r;
  assign LoadStore_MemWR_Out      = memWr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: three instances (WAIT_CYCLES 1, 3, 2)
// share one clock; a monitor pops expected Done responses from a queue.
module tb_load_store_unit;

  typedef struct {
    int          unit;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req, wr, busy, done, err, memRd, memWr;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] dout [3];
  logic [31:0] memAddr [3];
  logic [31:0] memDataOut [3];
  logic [31:0] memDataIn [3];

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  int   lastDone2 = 0;
  int   gap2 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Combinational data memory contents.
  function automatic logic [31:0] memModel(input logic [31:0] a);
    case (a)
      32'h0000_0800: memModel = 32'hc200_2004;
      32'h0000_0824: memModel = 32'h10bf_fffb;
      32'h0000_0008: memModel = 32'h0000_0005;
      32'h0000_0804: memModel = 32'hbad0_0804;
      default:       memModel = 32'h0000_0000;
    endcase
  endfunction

  always_comb begin
    for (int u = 0; u < 3; u++) memDataIn[u] = memModel(memAddr[u]);
  end

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    load_store_unit #(.DATAWIDTH_BUS(32), .WAIT_CYCLES(W)) dut (
      .LoadStore_CLOCK_50      (clk),
      .LoadStore_RESET_InHigh  (rst),
      .LoadStore_Req_In        (req[g]),
      .LoadStore_Write_In      (wr[g]),
      .LoadStore_Address_In    (addr[g]),
      .LoadStore_Data_In       (wdata[g]),
      .LoadStore_Data_Out      (dout[g]),
      .LoadStore_Busy_Out      (busy[g]),
      .LoadStore_Done_Out      (done[g]),
      .LoadStore_Error_Out     (err[g]),
      .LoadStore_MemAddress_Out(memAddr[g]),
      .LoadStore_MemData_Out   (memDataOut[g]),
      .LoadStore_MemRD_Out     (memRd[g]),
      .LoadStore_MemWR_Out     (memWr[g]),
      .LoadStore_MemData_In    (memDataIn[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest expected response.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (memRd[u] === 1'b1 && memWr[u] === 1'b1) begin
        miscompares++;
        $display("FAIL selectors unit%0d: both RD and WR high", u);
      end
      if (done[u] === 1'b1) begin
        if (u == 2) begin
          gap2 = cycle - lastDone2;
          lastDone2 = cycle;
        end
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done unit%0d: got Done, expected none", u);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          chk("done_unit", u, e.unit);
          chk("done_error", {31'd0, err[u]}, {31'd0, e.err});
          chk("done_data", dout[u], e.data);
        end
      end
    end
  end

  // One request with cycle-by-cycle handshake checks; optional stray Req while busy.
  task automatic runAccess(input int u, input int w, input logic isWr, input logic [31:0] a,
                           input logic [31:0] d, input logic expErr, input logic [31:0] expData,
                           input logic stray);
    exp_t e;
    @(negedge clk);
    req[u] = 1'b1; wr[u] = isWr; addr[u] = a; wdata[u] = d;
    e.unit = u; e.err = expErr; e.data = expData;
    expQ.push_back(e);
    @(negedge clk);
    req[u] = 1'b0;
    if (stray) begin
      req[u] = 1'b1; wr[u] = 1'b0; addr[u] = 32'h0000_0804;
    end
    if (expErr) begin
      chk("err_busy", {31'd0, busy[u]}, 32'd1);
      chk("err_done", {31'd0, done[u]}, 32'd1);
      chk("err_flag", {31'd0, err[u]}, 32'd1);
      chk("err_sel", {30'd0, memRd[u], memWr[u]}, 32'd0);
      @(negedge clk);
      chk("err_idle", {30'd0, busy[u], done[u]}, 32'd0);
    end else begin
      for (int c = 1; c <= w; c++) begin
        chk("acc_busy", {31'd0, busy[u]}, 32'd1);
        chk("acc_done", {31'd0, done[u]}, 32'd0);
        chk("acc_rd", {31'd0, memRd[u]}, {31'd0, ~isWr});
        chk("acc_wr", {31'd0, memWr[u]}, {31'd0, isWr});
        chk("acc_addr", memAddr[u], a);
        chk("acc_wdata", memDataOut[u], d);
        @(negedge clk);
      end
      chk("fin_done", {31'd0, done[u]}, 32'd1);
      chk("fin_busy", {31'd0, busy[u]}, 32'd1);
      chk("fin_sel", {30'd0, memRd[u], memWr[u]}, 32'd0);
      @(negedge clk);
      req[u] = 1'b0;
      chk("idle_busy", {30'd0, busy[u], done[u]}, 32'd0);
      chk("idle_addr", memAddr[u], a);
    end
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; wr = 3'b000;
    for (int u = 0; u < 3; u++) begin
      addr[u] = 32'h0; wdata[u] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_dout", dout[u], 32'h0);
      chk("rst_ctl", {26'd0, busy[u], done[u], err[u], memRd[u], memWr[u], 1'b0}, 32'h0);
      chk("rst_maddr", memAddr[u], 32'h0);
      chk("rst_mdata", memDataOut[u], 32'h0);
    end
    rst = 1'b0;

    // Unit 0, WAIT_CYCLES=1: load, misaligned load, load with stray Req while busy.
    runAccess(0, 1, 1'b0, 32'h0000_0800, 32'h0, 1'b0, 32'hc200_2004, 1'b0);
    runAccess(0, 1, 1'b0, 32'h0000_0802, 32'h0, 1'b1, 32'hc200_2004, 1'b0);
    runAccess(0, 1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h0000_0005, 1'b1);
    repeat (3) @(negedge clk);
    chk("stray_ignored", {30'd0, busy[0], done[0]}, 32'd0);
    chk("stray_addr", memAddr[0], 32'h0000_0008);

    // Unit 1, WAIT_CYCLES=3: store leaves Data_Out at its reset value.
    runAccess(1, 3, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);

    // Unit 2, WAIT_CYCLES=2: back-to-back loads with Req held.
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h0000_0800;
    expQ.push_back('{2, 1'b0, 32'hc200_2004});
    expQ.push_back('{2, 1'b0, 32'h10bf_fffb});
    @(negedge clk);
    addr[2] = 32'h0000_0824;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done1", {31'd0, done[2]}, 32'd1);
    @(negedge clk);
    chk("b2b_idle", {30'd0, busy[2], done[2]}, 32'd0);
    @(negedge clk);
    req[2] = 1'b0;
    chk("b2b_rd2", {31'd0, memRd[2]}, 32'd1);
    chk("b2b_addr2", memAddr[2], 32'h0000_0824);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done2", {31'd0, done[2]}, 32'd1);
    @(negedge clk);
    chk("b2b_gap", gap2, 32'd4);
    chk("b2b_dout", dout[2], 32'h10bf_fffb);

    // Unit 1: asynchronous reset in the middle of a store; no Done may follow.
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h0000_0010; wdata[1] = 32'h1234_5678;
    @(negedge clk);
    req[1] = 1'b0;
    chk("mid_wr", {31'd0, memWr[1]}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_wr", {31'd0, memWr[1]}, 32'd0);
    chk("async_ctl", {29'd0, busy[1], done[1], memRd[1]}, 32'd0);
    chk("async_maddr", memAddr[1], 32'h0);
    chk("async_mdata", memDataOut[1], 32'h0);
    chk("async_dout0", dout[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy[1]}, 32'd0);
    chk("queue_empty", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
